// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive packet controller
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SYNC_CHK,
        ST_RCV,
        ST_STORE,
        ST_EOP_DONE,
        ST_ERR_WAIT
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'h80;
    localparam int         BITS_PER_BYTE = 8;
    localparam int         MAX_BYTES     = 64;
    localparam int         BIT_CNT_W     = $clog2(BITS_PER_BYTE);
    localparam int         BYTE_CNT_W    = 7;

endpackage

// File: rtl/rx_bit_counter.sv
// rtl/rx_bit_counter.sv - bit-within-byte counter with byte completion strobe
module rx_bit_counter
    import usb_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 count_en,
    output logic [BIT_CNT_W-1:0] count,
    output logic                 rollover
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

    // The last bit of a byte completes it; the counter wraps on that same pulse.
    assign rollover = count_en && (count == LAST_BIT);

    // Count sampled bits; clear has priority so a new packet always starts at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= (count == LAST_BIT) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_pkt_ctrl.sv
// rtl/rx_pkt_ctrl.sv - USB receive packet sequencer driving the rx_fifo write side
module rx_pkt_ctrl
    import usb_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_edge,
    input  logic                  shift_enable,
    input  logic                  eop,
    input  logic [7:0]            rcv_data,
    input  logic                  fifo_full,
    output logic                  rcving,
    output logic                  w_enable,
    output logic                  r_error,
    output logic                  pkt_done,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_BYTES);

    rx_state_t              state;
    rx_state_t              next_state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   byte_done;
    logic                   count_en;
    logic                   write_ok;
    logic                   rcving_d;
    logic                   w_enable_d;
    logic                   r_error_d;
    logic                   pkt_done_d;
    logic [BYTE_CNT_W-1:0]  byte_count_d;

    // Bits keep counting through SYNC_CHK and STORE so a bit landing there is not lost.
    assign count_en = shift_enable && (state inside {ST_SYNC, ST_SYNC_CHK, ST_RCV, ST_STORE});

    // The write decision is made on the byte_done cycle so w_enable can be a register
    // that is high during STORE; the byte cap keeps byte_count from ever passing MAX_BYTES.
    assign write_ok = !fifo_full && (byte_count != MAX_CNT);

    rx_bit_counter u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_IDLE),
        .count_en (count_en),
        .count    (bit_cnt),
        .rollover (byte_done)
    );

    // State and registered outputs; reset discards any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rcving     <= 1'b0;
            w_enable   <= 1'b0;
            r_error    <= 1'b0;
            pkt_done   <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= next_state;
            rcving     <= rcving_d;
            w_enable   <= w_enable_d;
            r_error    <= r_error_d;
            pkt_done   <= pkt_done_d;
            byte_count <= byte_count_d;
        end
    end

    // Next state plus the values the output registers take on entering it.
    always_comb begin
        next_state   = state;
        rcving_d     = rcving;
        w_enable_d   = 1'b0;
        r_error_d    = r_error;
        pkt_done_d   = 1'b0;
        byte_count_d = byte_count;
        case (state)
            ST_IDLE: begin
                if (d_edge) begin
                    next_state   = ST_SYNC;
                    rcving_d     = 1'b1;
                    r_error_d    = 1'b0;
                    byte_count_d = '0;
                end
            end
            ST_SYNC: begin
                if (eop) begin
                    next_state = ST_ERR_WAIT;
                    r_error_d  = 1'b1;
                end else if (byte_done) begin
                    next_state = ST_SYNC_CHK;
                end
            end
            ST_SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) begin
                    next_state = ST_RCV;
                end else begin
                    next_state = ST_ERR_WAIT;
                    r_error_d  = 1'b1;
                end
            end
            ST_RCV: begin
                if (eop && shift_enable && (bit_cnt == '0)) begin
                    next_state = ST_EOP_DONE;
                    rcving_d   = 1'b0;
                    pkt_done_d = 1'b1;
                end else if (eop && (bit_cnt != '0)) begin
                    next_state = ST_ERR_WAIT;
                    r_error_d  = 1'b1;
                end else if (byte_done) begin
                    next_state = ST_STORE;
                    if (write_ok) begin
                        w_enable_d   = 1'b1;
                        byte_count_d = byte_count + 1'b1;
                    end else begin
                        r_error_d = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                next_state = w_enable ? ST_RCV : ST_ERR_WAIT;
            end
            ST_EOP_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERR_WAIT: begin
                r_error_d = 1'b1;
                if (eop && shift_enable) begin
                    next_state = ST_IDLE;
                    rcving_d   = 1'b0;
                end
            end
            default: begin
                next_state = ST_IDLE;
                rcving_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb/tb_rx_pkt_ctrl.sv - scoreboard bench for rx_pkt_ctrl
module tb_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_edge;
    logic       shift_enable;
    logic       eop;
    logic [7:0] rcv_data;
    logic       fifo_full;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic       pkt_done;
    logic [6:0] byte_count;

    int         total = 0;
    int         bad = 0;
    int         pkt_cnt = 0;
    logic [7:0] exp_q[$];

    rx_pkt_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .eop          (eop),
        .rcv_data     (rcv_data),
        .fifo_full    (fifo_full),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .pkt_done     (pkt_done),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_enable) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write got=%h expected=none", rcv_data);
                end else begin
                    chk("write_data", int'(rcv_data), int'(exp_q.pop_front()));
                end
            end
            if (pkt_done) pkt_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sampled bit: strobe, then the shift register updates LSB-first.
    task automatic send_bit(input logic b);
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        rcv_data = {b, rcv_data[7:1]};
        tick();
        tick();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic eop_bit();
        eop = 1'b1;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        eop = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        d_edge = 1'b0;
        shift_enable = 1'b0;
        eop = 1'b0;
        fifo_full = 1'b0;
        rcv_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int p0;
        apply_reset();
        chk("rst_rcving", rcving, 0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_r_error", r_error, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_byte_count", byte_count, 0);

        // Good packet
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        start_pkt();
        chk("good_rcving_start", rcving, 1);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h3C);
        eop_bit();
        chk("good_pkt_done", pkt_cnt, 1);
        chk("good_byte_count", byte_count, 2);
        chk("good_r_error", r_error, 0);
        chk("good_rcving_end", rcving, 0);
        chk("good_q_empty", exp_q.size(), 0);

        // Bad SYNC
        start_pkt();
        send_byte(8'h81);
        chk("badsync_r_error", r_error, 1);
        chk("badsync_rcving", rcving, 1);
        eop_bit();
        chk("badsync_rcving_end", rcving, 0);
        chk("badsync_r_error_held", r_error, 1);
        start_pkt();
        chk("badsync_r_error_clear", r_error, 0);
        apply_reset();

        // Partial-byte EOP
        p0 = pkt_cnt;
        exp_q.push_back(8'hAA);
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hAA);
        send_bits(8'h05, 3);
        eop = 1'b1;
        tick();
        chk("partial_r_error", r_error, 1);
        chk("partial_rcving", rcving, 1);
        eop_bit();
        chk("partial_rcving_end", rcving, 0);
        chk("partial_no_pkt_done", pkt_cnt, p0);
        chk("partial_byte_count", byte_count, 1);
        chk("partial_q_empty", exp_q.size(), 0);

        // Overflow on the second data byte
        exp_q.push_back(8'h11);
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h11);
        fifo_full = 1'b1;
        send_byte(8'h22);
        fifo_full = 1'b0;
        chk("ovf_byte_count", byte_count, 1);
        chk("ovf_r_error", r_error, 1);
        eop_bit();
        chk("ovf_rcving_end", rcving, 0);
        chk("ovf_q_empty", exp_q.size(), 0);

        // Length cap: 65 data bytes, only 64 written
        start_pkt();
        send_byte(8'h80);
        for (int i = 0; i < 65; i++) begin
            if (i < 64) exp_q.push_back(8'(i * 3 + 1));
            send_byte(8'(i * 3 + 1));
        end
        chk("cap_byte_count", byte_count, 64);
        chk("cap_r_error", r_error, 1);
        eop_bit();
        chk("cap_rcving_end", rcving, 0);
        chk("cap_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-byte (bit_cnt = 5)
        start_pkt();
        send_byte(8'h80);
        send_bits(8'h1F, 5);
        chk("midrst_rcving_before", rcving, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rcving", rcving, 0);
        chk("midrst_w_enable", w_enable, 0);
        chk("midrst_r_error", r_error, 0);
        tick();
        rst = 1'b0;
        send_bits(8'hFF, 3);
        tick();
        chk("midrst_no_write", exp_q.size(), 0);
        chk("midrst_idle", rcving, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
